// File: rtl/instr_loader_pkg.sv
// Shared types and constants for the instruction-memory loader.
package instr_loader_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LEN_HI,
        LEN_LO,
        DATA,
        WRITE,
        CHK,
        DONE,
        ERR
    } state_t;

    localparam int BYTES_PER_WORD = 4;
    localparam int LEN_W          = 16;
    localparam int IDX_W          = $clog2(BYTES_PER_WORD);

endpackage

// File: rtl/instr_mem_loader_if.sv
// Byte-stream, memory write port and status bundle of the loader.
// master drives the stream and start; slave (the loader) drives the rest.
interface instr_mem_loader_if;
    import instr_loader_pkg::*;

    logic             start;
    logic             byte_valid;
    logic [7:0]       byte_data;
    logic             byte_ready;
    logic             mem_we;
    logic [31:0]      mem_addr;
    logic [31:0]      mem_wdata;
    logic             cpu_hold;
    logic             done;
    logic             error;
    logic [LEN_W-1:0] words_written;

    modport master (
        output start, byte_valid, byte_data,
        input  byte_ready, mem_we, mem_addr, mem_wdata,
        input  cpu_hold, done, error, words_written
    );

    modport slave (
        input  start, byte_valid, byte_data,
        output byte_ready, mem_we, mem_addr, mem_wdata,
        output cpu_hold, done, error, words_written
    );

endinterface

// File: rtl/byte_to_word_packer.sv
// Packs a byte stream big-endian into 32-bit words.
// Latency: word register updates on the accepting edge; word_ready flags the 4th byte combinationally.
// Backpressure: none of its own; shifts only when the caller asserts shift.
module byte_to_word_packer
    import instr_loader_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clear,
    input  logic        shift,
    input  logic [7:0]  byte_in,
    output logic [31:0] word,
    output logic        word_ready
);

    logic [IDX_W-1:0] idx;
    logic [31:0]      word_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            idx    <= '0;
            word_q <= '0;
        end else begin
            if (clear) begin
                idx <= '0;
            end else if (shift) begin
                idx <= idx + 1'b1;
            end
            if (shift) begin
                word_q <= {word_q[23:0], byte_in};
            end
        end
    end

    assign word       = word_q;
    assign word_ready = shift && (idx == IDX_W'(BYTES_PER_WORD - 1));

endmodule

// File: rtl/instr_mem_loader.sv
// Loads a length-prefixed byte stream into instruction memory, holding the CPU meanwhile.
// Latency: 4th byte of a word accepted in cycle t -> mem_we in t+1; at best 1 word per 5 cycles.
// Backpressure: byte_valid low stalls any state; byte_ready drops in IDLE/WRITE/DONE/ERR. Option: INSTR_LOADER_CHECKSUM_EN.
module instr_mem_loader
    import instr_loader_pkg::*;
#(
    parameter int          DEPTH     = 256,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
)(
    input  logic              clk,
    input  logic              rst_n,
    instr_mem_loader_if.slave bus
);

    localparam logic [LEN_W:0] DEPTH_L = (LEN_W + 1)'(DEPTH);

    state_t           state;
    state_t           state_nxt;
    logic [LEN_W-1:0] len;
    logic [LEN_W-1:0] len_full;
    logic [LEN_W-1:0] words_written;
    logic             error_q;
    logic             xfer;
    logic             pk_clear;
    logic             pk_shift;
    logic             word_ready;
    logic [31:0]      word;

`ifdef INSTR_LOADER_CHECKSUM_EN
    logic [7:0] csum;
`endif

    assign xfer     = bus.byte_valid && bus.byte_ready;
    assign pk_shift = xfer && (state == DATA);
    assign len_full = {len[LEN_W-1 -: 8], bus.byte_data};

    byte_to_word_packer u_packer (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear      (pk_clear),
        .shift      (pk_shift),
        .byte_in    (bus.byte_data),
        .word       (word),
        .word_ready (word_ready)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        pk_clear  = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start) state_nxt = LEN_HI;
            end
            LEN_HI: begin
                if (xfer) state_nxt = LEN_LO;
            end
            LEN_LO: begin
                if (xfer) begin
                    pk_clear = 1'b1;
                    if (len_full == '0) begin
                        state_nxt = DONE;
                    end else if ({1'b0, len_full} > DEPTH_L) begin
                        state_nxt = ERR;
                    end else begin
                        state_nxt = DATA;
                    end
                end
            end
            DATA: begin
                if (word_ready) state_nxt = WRITE;
            end
            WRITE: begin
                if (words_written + 1'b1 == len) begin
`ifdef INSTR_LOADER_CHECKSUM_EN
                    state_nxt = CHK;
`else
                    state_nxt = DONE;
`endif
                end else begin
                    state_nxt = DATA;
                end
            end
`ifdef INSTR_LOADER_CHECKSUM_EN
            CHK: begin
                if (xfer) state_nxt = (bus.byte_data == csum) ? DONE : ERR;
            end
`endif
            DONE:    state_nxt = IDLE;
            ERR:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Session bookkeeping; error is sticky until the next accepted start.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            len           <= '0;
            words_written <= '0;
            error_q       <= 1'b0;
        end else begin
            if (state == IDLE && bus.start) begin
                words_written <= '0;
                error_q       <= 1'b0;
            end
            if (state == LEN_HI && xfer) len[LEN_W-1 -: 8] <= bus.byte_data;
            if (state == LEN_LO && xfer) len[7:0]          <= bus.byte_data;
            if (state == WRITE)          words_written     <= words_written + 1'b1;
            if (state_nxt == ERR)        error_q           <= 1'b1;
        end
    end

`ifdef INSTR_LOADER_CHECKSUM_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            csum <= '0;
        end else if (state == IDLE && bus.start) begin
            csum <= '0;
        end else if (xfer && (state inside {LEN_HI, LEN_LO, DATA})) begin
            csum <= csum ^ bus.byte_data;
        end
    end
`endif

    assign bus.byte_ready    = state inside {LEN_HI, LEN_LO, DATA, CHK};
    assign bus.mem_we        = (state == WRITE);
    assign bus.mem_addr      = BASE_ADDR + 32'(words_written) * 32'(BYTES_PER_WORD);
    assign bus.mem_wdata     = word;
    assign bus.cpu_hold      = state inside {LEN_HI, LEN_LO, DATA, WRITE, CHK};
    assign bus.done          = (state == DONE);
    assign bus.error         = error_q;
    assign bus.words_written = words_written;

endmodule

// File: tb/tb_instr_mem_loader.sv
// Directed bench for instr_mem_loader: nominal, zero/oversize length, stalls, mid-session reset.
module tb_instr_mem_loader;

    localparam logic [31:0] BASE = 32'h0000_1000;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    instr_mem_loader_if bus ();

    instr_mem_loader #(
        .DEPTH     (256),
        .BASE_ADDR (BASE)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, want 0x%08h", tag, act, exp);
        end
    endtask

    int          wr_cnt    = 0;
    int          done_cnt  = 0;
    int          rdy_in_wr = 0;
    logic [31:0] wr_addr [64];
    logic [31:0] wr_data [64];

    always @(negedge clk) begin
        if (bus.mem_we) begin
            if (wr_cnt < 64) begin
                wr_addr[wr_cnt] <= bus.mem_addr;
                wr_data[wr_cnt] <= bus.mem_wdata;
            end
            wr_cnt <= wr_cnt + 1;
            if (bus.byte_ready) rdy_in_wr <= rdy_in_wr + 1;
        end
        if (bus.done) done_cnt <= done_cnt + 1;
    end

    task automatic pulse_start();
        @(negedge clk);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    // Returns #1 after the edge on which the byte was accepted.
    task automatic send_byte(input logic [7:0] b, input int gap, input bit poke_start);
        int t;
        t = 0;
        if (poke_start) begin
            @(negedge clk);
            bus.start = 1'b1;
            @(negedge clk);
            bus.start = 1'b0;
        end
        repeat (gap) @(negedge clk);
        @(negedge clk);
        bus.byte_valid = 1'b1;
        bus.byte_data  = b;
        while (!bus.byte_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (t >= 50) chk("rdy_timeout", 32'(t), 32'd0);
        @(posedge clk);
        #1;
        bus.byte_valid = 1'b0;
    endtask

    logic [31:0] prog [4];

    task automatic send_prog(input int n, input int max_gap, input bit bad_csum);
        logic [7:0]  cs;
        logic [7:0]  b;
        logic [15:0] len16;
        cs    = 8'h00;
        len16 = 16'(n);
        pulse_start();
        b = len16[15:8]; cs ^= b; send_byte(b, 0, 1'b0);
        b = len16[7:0];  cs ^= b; send_byte(b, 0, 1'b0);
        for (int w = 0; w < n; w++) begin
            for (int k = 3; k >= 0; k--) begin
                b   = prog[w][8*k +: 8];
                cs ^= b;
                send_byte(b, int'($urandom_range(0, max_gap)), (max_gap > 0) && (w == 1) && (k == 2));
            end
        end
`ifdef INSTR_LOADER_CHECKSUM_EN
        send_byte(bad_csum ? ~cs : cs, 0, 1'b0);
`else
        if (bad_csum) chk("csum_unsupported", 32'd1, 32'(n));
`endif
    endtask

    task automatic wait_end(output bit saw_done, output bit saw_err);
        int i;
        i = 0;
        saw_done = 1'b0;
        saw_err  = 1'b0;
        while (!(bus.done || bus.error) && i < 100) begin
            @(negedge clk);
            i++;
        end
        saw_done = bus.done;
        saw_err  = bus.error;
        if (i >= 100) chk("end_timeout", 32'(i), 32'd0);
    endtask

    bit sd, se;
    int wb, db;

    initial begin
        bus.start      = 1'b0;
        bus.byte_valid = 1'b0;
        bus.byte_data  = 8'h00;
        repeat (3) @(negedge clk);

        chk("rst_byte_ready", 32'(bus.byte_ready), 32'd0);
        chk("rst_mem_we",     32'(bus.mem_we),     32'd0);
        chk("rst_cpu_hold",   32'(bus.cpu_hold),   32'd0);
        chk("rst_done",       32'(bus.done),       32'd0);
        chk("rst_error",      32'(bus.error),      32'd0);
        chk("rst_mem_addr",   bus.mem_addr,        BASE);
        chk("rst_mem_wdata",  bus.mem_wdata,       32'h0);
        chk("rst_words",      32'(bus.words_written), 32'd0);
        rst_n = 1'b1;

        // Nominal two-word load
        prog[0] = 32'h2008_0005;
        prog[1] = 32'h0109_5020;
        wb = wr_cnt; db = done_cnt;
        send_prog(2, 0, 1'b0);
        wait_end(sd, se);
        chk("nom_done",      32'(sd), 32'd1);
        chk("nom_error",     32'(se), 32'd0);
        chk("nom_hold_done", 32'(bus.cpu_hold), 32'd0);
        repeat (2) @(negedge clk);
        chk("nom_writes", 32'(wr_cnt - wb), 32'd2);
        chk("nom_addr0",  wr_addr[wb],     BASE);
        chk("nom_data0",  wr_data[wb],     32'h2008_0005);
        chk("nom_addr1",  wr_addr[wb + 1], BASE + 32'h4);
        chk("nom_data1",  wr_data[wb + 1], 32'h0109_5020);
        chk("nom_words",  32'(bus.words_written), 32'd2);
        chk("nom_done_pulses", 32'(done_cnt - db), 32'd1);
        chk("nom_done_low",    32'(bus.done), 32'd0);

        // Zero length: done right after the low length byte
        wb = wr_cnt;
        pulse_start();
        chk("zero_hold_busy", 32'(bus.cpu_hold), 32'd1);
        send_byte(8'h00, 0, 1'b0);
        send_byte(8'h00, 0, 1'b0);
        chk("zero_done",  32'(bus.done),     32'd1);
        chk("zero_hold",  32'(bus.cpu_hold), 32'd0);
        repeat (2) @(negedge clk);
        chk("zero_done_low", 32'(bus.done),  32'd0);
        chk("zero_error",    32'(bus.error), 32'd0);
        chk("zero_writes",   32'(wr_cnt - wb), 32'd0);

        // Oversize: 257 > DEPTH
        wb = wr_cnt; db = done_cnt;
        pulse_start();
        send_byte(8'h01, 0, 1'b0);
        send_byte(8'h01, 0, 1'b0);
        chk("over_error", 32'(bus.error),    32'd1);
        chk("over_hold",  32'(bus.cpu_hold), 32'd0);
        repeat (3) @(negedge clk);
        chk("over_sticky", 32'(bus.error),      32'd1);
        chk("over_ready",  32'(bus.byte_ready), 32'd0);
        chk("over_writes", 32'(wr_cnt - wb),    32'd0);
        chk("over_no_done", 32'(done_cnt - db), 32'd0);

        // Stalled three-word load with a stray start mid-session
        prog[0] = 32'hAABB_CCDD;
        prog[1] = 32'h1122_3344;
        prog[2] = 32'h0F0E_0D0C;
        wb = wr_cnt;
        send_prog(3, 3, 1'b0);
        wait_end(sd, se);
        chk("stall_done",  32'(sd), 32'd1);
        chk("stall_error", 32'(se), 32'd0);
        repeat (2) @(negedge clk);
        chk("stall_writes", 32'(wr_cnt - wb), 32'd3);
        for (int i = 0; i < 3; i++) begin
            chk("stall_addr", wr_addr[wb + i], BASE + 32'(4 * i));
            chk("stall_data", wr_data[wb + i], prog[i]);
        end
        chk("stall_words",    32'(bus.words_written), 32'd3);
        chk("ready_in_write", 32'(rdy_in_wr), 32'd0);

        // Mid-session reset after five data bytes
        wb = wr_cnt;
        pulse_start();
        send_byte(8'h00, 0, 1'b0);
        send_byte(8'h02, 0, 1'b0);
        send_byte(8'h20, 0, 1'b0);
        send_byte(8'h08, 0, 1'b0);
        send_byte(8'h00, 0, 1'b0);
        send_byte(8'h05, 0, 1'b0);
        chk("lat_mem_we", 32'(bus.mem_we),     32'd1);
        chk("lat_ready",  32'(bus.byte_ready), 32'd0);
        chk("lat_addr",   bus.mem_addr,        BASE);
        chk("lat_wdata",  bus.mem_wdata,       32'h2008_0005);
        chk("lat_hold",   32'(bus.cpu_hold),   32'd1);
        send_byte(8'hAA, 0, 1'b0);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        chk("mrst_hold",  32'(bus.cpu_hold),      32'd0);
        chk("mrst_ready", 32'(bus.byte_ready),    32'd0);
        chk("mrst_we",    32'(bus.mem_we),        32'd0);
        chk("mrst_addr",  bus.mem_addr,           BASE);
        chk("mrst_wdata", bus.mem_wdata,          32'h0);
        chk("mrst_words", 32'(bus.words_written), 32'd0);
        chk("mrst_error", 32'(bus.error),         32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        chk("mrst_kept_writes", 32'(wr_cnt - wb), 32'd1);
        prog[0] = 32'hDEAD_BEEF;
        wb = wr_cnt;
        send_prog(1, 0, 1'b0);
        wait_end(sd, se);
        chk("reload_done", 32'(sd), 32'd1);
        repeat (2) @(negedge clk);
        chk("reload_writes", 32'(wr_cnt - wb), 32'd1);
        chk("reload_addr",   wr_addr[wb],      BASE);
        chk("reload_data",   wr_data[wb],      32'hDEAD_BEEF);

`ifdef INSTR_LOADER_CHECKSUM_EN
        prog[0] = 32'h1234_5678;
        send_prog(1, 0, 1'b0);
        wait_end(sd, se);
        chk("csum_ok_done",  32'(sd), 32'd1);
        chk("csum_ok_error", 32'(se), 32'd0);
        wb = wr_cnt;
        send_prog(1, 0, 1'b1);
        wait_end(sd, se);
        chk("csum_bad_error", 32'(se), 32'd1);
        chk("csum_bad_done",  32'(sd), 32'd0);
        repeat (2) @(negedge clk);
        chk("csum_bad_writes", 32'(wr_cnt - wb), 32'd1);
        chk("csum_bad_data",   wr_data[wb],      32'h1234_5678);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
